// File: rtl/i2c_slave_target.sv
// I2C target: oversamples scl/sda on the system clock, detects START/STOP, matches a 7-bit
// address, ACKs, assembles written bytes and serialises read bytes fetched over a request pulse.
module i2c_slave_target #(
    parameter logic [6:0] ADDR = 7'h2d
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_RX        = 4'd3,
        ST_RX_ACK    = 4'd4,
        ST_TX        = 4'd5,
        ST_TX_ACK    = 4'd6,
        ST_WAIT_STOP = 4'd7
    } state_t;

    logic       scl_r_q, sda_r_q, scl_q, sda_q;
    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_out_q, sda_out_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] shift_in;

    always_comb begin
        scl_rise  = scl_r_q & ~scl_q;
        scl_fall  = ~scl_r_q & scl_q;
        // Bus conditions need scl high on both samples so sda moves under a low scl stay data.
        start_det = scl_r_q & scl_q & sda_q & ~sda_r_q;
        stop_det  = scl_r_q & scl_q & ~sda_q & sda_r_q;
        shift_in  = {shift_q[6:0], sda_r_q};
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        sda_out_d  = sda_out_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        rw_d       = rw_q;

        if (stop_det) begin
            state_d   = ST_IDLE;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (shift_in[7:1] == ADDR) begin
                                state_d  = ST_ADDR_ACK;
                                busy_d   = 1'b1;
                                rw_d     = shift_in[0];
                                tx_req_d = shift_in[0];
                            end else begin
                                state_d = ST_WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // bit_cnt doubles as the ACK phase: 0 = waiting to pull low, 1 = holding low.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_out_d = 1'b0;
                            bit_cnt_d = 4'd1;
                        end else begin
                            bit_cnt_d = 4'd0;
                            if (rw_q) begin
                                shift_d   = tx_data;
                                sda_out_d = tx_data[7];
                                state_d   = ST_TX;
                            end else begin
                                sda_out_d = 1'b1;
                                state_d   = ST_RX;
                            end
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = 4'd0;
                            state_d    = ST_RX_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_out_d = 1'b0;
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_out_d = 1'b1;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RX;
                        end
                    end
                end
                ST_TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_out_d = 1'b1;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_TX_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_out_d = shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (bit_cnt_q == 4'd0) begin
                        if (scl_rise) begin
                            if (!sda_r_q) begin
                                tx_req_d  = 1'b1;
                                bit_cnt_d = 4'd1;
                            end else begin
                                sda_out_d = 1'b1;
                                state_d   = ST_WAIT_STOP;
                            end
                        end
                    end else if (scl_fall) begin
                        shift_d   = tx_data;
                        sda_out_d = tx_data[7];
                        bit_cnt_d = 4'd0;
                        state_d   = ST_TX;
                    end
                end
                ST_WAIT_STOP: sda_out_d = 1'b1;
                default: begin
                    state_d   = ST_IDLE;
                    sda_out_d = 1'b1;
                    busy_d    = 1'b0;
                    bit_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_r_q    <= 1'b1;
            sda_r_q    <= 1'b1;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            sda_out_q  <= 1'b1;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            scl_r_q    <= scl_in;
            sda_r_q    <= sda_in;
            scl_q      <= scl_r_q;
            sda_q      <= sda_r_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            sda_out_q  <= sda_out_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
        end
    end

    assign sda_out  = sda_out_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;
    assign state    = state_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a bit-level master drives the wired-AND bus; rx_valid/tx_req
// events are matched against an expected queue by an independent monitor.
module tb_i2c_slave_target;

    localparam int Q = 8;  // system clocks per scl half-period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_in = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int low_cnt = 0;
    logic [8:0] exp_q[$];  // {is_tx_req, rx byte}

    assign sda_in = sda_m & sda_out;

    i2c_slave_target #(.ADDR(7'h2d)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in), .sda_out(sda_out),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sda_out == 1'b0) low_cnt++;
            if (rx_valid || tx_req) begin
                check("event_exclusive", {31'd0, rx_valid & tx_req}, 32'd0);
                check("event_inside_busy", {31'd0, busy}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got tx_req=%0b rx_data=%0h expected none",
                             tx_req, rx_data);
                end else begin
                    check("scoreboard_event", {23'd0, tx_req, (tx_req ? 8'h00 : rx_data)},
                          {23'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic glitch, output logic seen);
        if (glitch) begin
            sda_m = ~b; tick(1);
            sda_m = b;  tick(1);
            sda_m = ~b; tick(1);
        end
        sda_m = b;
        tick(Q);
        scl_in = 1'b1;
        tick(Q);
        seen = sda_in;
        scl_in = 1'b0;
        tick(2);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic glitch, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch, s);
        send_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        send_bit(mack, 1'b0, s);
    endtask

    task automatic start_cond();
        if (!scl_in) begin
            sda_m = 1'b1; tick(Q);
            scl_in = 1'b1; tick(Q);
        end
        sda_m = 1'b0; tick(Q);
        scl_in = 1'b0; tick(2);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; tick(Q);
        scl_in = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         low_before;

        // Reset
        rst_n = 1'b0;
        tick(4);
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_sda_out", {31'd0, sda_out}, 32'd1);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_flags", {29'd0, rx_valid, tx_req, busy}, 32'd0);
        rst_n = 1'b1;
        tick(4);

        // 1: write 0xA5 to our address
        start_cond();
        write_byte(8'h5A, 1'b0, ack);
        check("t1_addr_ack", {31'd0, ack}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back(9'h0A5);
        write_byte(8'hA5, 1'b0, ack);
        check("t1_data_ack", {31'd0, ack}, 32'd0);
        stop_cond();
        check("t1_state_idle", {28'd0, state}, 32'd0);
        check("t1_busy_clear", {31'd0, busy}, 32'd0);
        check("t1_rx_data", {24'd0, rx_data}, 32'hA5);
        check("t1_queue_empty", exp_q.size(), 32'd0);

        // 2: address mismatch
        low_before = low_cnt;
        start_cond();
        write_byte(8'h30, 1'b0, ack);
        check("t2_addr_nack", {31'd0, ack}, 32'd1);
        check("t2_state_wait", {28'd0, state}, 32'd7);
        write_byte(8'hFF, 1'b0, ack);
        check("t2_state_still_wait", {28'd0, state}, 32'd7);
        stop_cond();
        check("t2_state_idle", {28'd0, state}, 32'd0);
        check("t2_sda_never_low", low_cnt - low_before, 32'd0);
        check("t2_queue_empty", exp_q.size(), 32'd0);

        // 3: read 0x3C then 0x81, NACK the second
        tx_data = 8'h3C;
        exp_q.push_back(9'h100);
        start_cond();
        write_byte(8'h5B, 1'b0, ack);
        check("t3_addr_ack", {31'd0, ack}, 32'd0);
        tx_data = 8'h81;
        exp_q.push_back(9'h100);
        read_byte(1'b0, d);
        check("t3_read0", {24'd0, d}, 32'h3C);
        read_byte(1'b1, d);
        check("t3_read1", {24'd0, d}, 32'h81);
        check("t3_state_wait", {28'd0, state}, 32'd7);
        check("t3_sda_released", {31'd0, sda_out}, 32'd1);
        stop_cond();
        check("t3_state_idle", {28'd0, state}, 32'd0);
        check("t3_queue_empty", exp_q.size(), 32'd0);

        // 4: write 0x11, repeated START, read one byte
        start_cond();
        write_byte(8'h5A, 1'b0, ack);
        check("t4_addr_ack", {31'd0, ack}, 32'd0);
        exp_q.push_back(9'h011);
        write_byte(8'h11, 1'b0, ack);
        check("t4_data_ack", {31'd0, ack}, 32'd0);
        tx_data = 8'h96;
        exp_q.push_back(9'h100);
        start_cond();
        write_byte(8'h5B, 1'b0, ack);
        check("t4_raddr_ack", {31'd0, ack}, 32'd0);
        check("t4_rx_data_kept", {24'd0, rx_data}, 32'h11);
        read_byte(1'b1, d);
        check("t4_read", {24'd0, d}, 32'h96);
        stop_cond();
        check("t4_state_idle", {28'd0, state}, 32'd0);
        check("t4_queue_empty", exp_q.size(), 32'd0);

        // 5a: STOP after 4 data bits
        start_cond();
        write_byte(8'h5A, 1'b0, ack);
        check("t5_addr_ack", {31'd0, ack}, 32'd0);
        send_bit(1'b1, 1'b0, s);
        send_bit(1'b0, 1'b0, s);
        send_bit(1'b1, 1'b0, s);
        send_bit(1'b1, 1'b0, s);
        stop_cond();
        check("t5_state_idle", {28'd0, state}, 32'd0);
        check("t5_busy_clear", {31'd0, busy}, 32'd0);
        check("t5_queue_empty", exp_q.size(), 32'd0);

        // 5b: reset while the address ACK is being driven
        start_cond();
        for (int i = 7; i >= 0; i--) send_bit(d[0] ^ d[0] ^ (8'h5A >> i) & 1'b1, 1'b0, s);
        sda_m = 1'b1;
        tick(Q);
        scl_in = 1'b1;
        tick(Q / 2);
        check("t5_ack_driven", {31'd0, sda_out}, 32'd0);
        rst_n = 1'b0;
        tick(1);
        check("t5_rst_sda_release", {31'd0, sda_out}, 32'd1);
        check("t5_rst_state", {28'd0, state}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        scl_in = 1'b0;
        tick(2);
        stop_cond();
        check("t5_post_rst_idle", {28'd0, state}, 32'd0);

        // 6: sda glitches while scl low must not disturb the byte
        start_cond();
        write_byte(8'h5A, 1'b1, ack);
        check("t6_addr_ack", {31'd0, ack}, 32'd0);
        exp_q.push_back(9'h069);
        write_byte(8'h69, 1'b1, ack);
        check("t6_data_ack", {31'd0, ack}, 32'd0);
        check("t6_state_rx", {28'd0, state}, 32'd3);
        stop_cond();
        check("t6_rx_data", {24'd0, rx_data}, 32'h69);
        check("t6_state_idle", {28'd0, state}, 32'd0);
        check("t6_queue_empty", exp_q.size(), 32'd0);

        tick(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
